// File: rtl/dpu_dma_pkg.sv
// Shared types for the DPU DMA descriptor path: target encoding, the descriptor
// record and the sequencer state encoding.
package dpu_dma_pkg;

    localparam int DMA_ADDR_BITS = 24;

    typedef enum logic [2:0] {
        TGT_WBUF  = 3'd0,
        TGT_FMAP  = 3'd1,
        TGT_BIAS  = 3'd2,
        TGT_SCALE = 3'd3,
        TGT_LDESC = 3'd4
    } dma_target_e;

    typedef struct packed {
        dma_target_e              target;
        logic [DMA_ADDR_BITS-1:0] base;
        logic [DMA_ADDR_BITS-1:0] length;
        logic                     dir;
        logic                     irq_en;
    } dma_desc_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_CMPL    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/dpu_desc_fifo.sv
// Synchronous descriptor FIFO with flush. The head entry is visible
// combinationally so the sequencer can capture it in its pop cycle.
module dpu_desc_fifo
    import dpu_dma_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  dma_desc_t                    push_data,
    input  logic                         pop,
    input  logic                         flush,
    output dma_desc_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    dma_desc_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_push;
    logic               w_pop;

    assign empty = (r_level == '0);
    assign full  = (r_level == LVL_W'(DEPTH));
    assign level = r_level;
    assign head  = r_mem[r_rd_ptr];

    // A flush swallows any push or pop presented in the same cycle.
    assign w_pop  = pop && !empty && !flush;
    assign w_push = push && !flush && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

endmodule

// File: rtl/dpu_dma_desc_seq.sv
// Descriptor sequencer feeding dpu_axi_dma: queues descriptors, drives the DMA CSR
// inputs, holds dma_start per transfer and performs the start/done release handshake.
module dpu_dma_desc_seq
    import dpu_dma_pkg::*;
#(
    parameter int ADDR_BITS = DMA_ADDR_BITS,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT_W = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        desc_valid,
    output logic                        desc_ready,
    input  logic [2:0]                  desc_target,
    input  logic [ADDR_BITS-1:0]        desc_base,
    input  logic [ADDR_BITS-1:0]        desc_length,
    input  logic                        desc_dir,
    input  logic                        desc_irq_en,
    input  logic                        flush,
    input  logic                        clr_err,
    output logic [2:0]                  dma_target,
    output logic [ADDR_BITS-1:0]        dma_base_addr,
    output logic [ADDR_BITS-1:0]        dma_length,
    output logic                        dma_dir,
    output logic                        dma_start,
    input  logic                        dma_done,
    input  logic                        dma_busy,
    output logic                        seq_busy,
    output logic [$clog2(DEPTH+1)-1:0]  q_level,
    output logic [15:0]                 done_cnt,
    output logic                        irq,
    output logic                        err_timeout
);

    seq_state_e             r_state;
    dma_desc_t              r_active;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic                   r_err;
    logic [15:0]            r_done_cnt;

    dma_desc_t              w_desc_in;
    dma_desc_t              w_head;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic [TIMEOUT_W-1:0]   w_wdog_nxt;
    logic                   w_wdog_inc;
    logic                   w_expire;

    assign w_desc_in = '{target: dma_target_e'(desc_target), base: desc_base,
                         length: desc_length, dir: desc_dir, irq_en: desc_irq_en};
    assign w_pop     = (r_state == S_IDLE) && !w_empty && !flush;

    dpu_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (desc_valid && desc_ready),
        .push_data (w_desc_in),
        .pop       (w_pop),
        .flush     (flush),
        .head      (w_head),
        .level     (q_level),
        .empty     (w_empty),
        .full      (w_full)
    );

    // dma_* only change in the pop cycle, so they stay stable through release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_active <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_active <= w_head;
                        r_state  <= (w_head.length == '0) ? S_CMPL : S_LAUNCH;
                    end
                end
                S_LAUNCH:  r_state <= S_RUN;
                S_RUN:     if (dma_done) r_state <= S_RELEASE;
                S_RELEASE: if (!dma_done) r_state <= S_CMPL;
                S_CMPL:    r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Watchdog saturates at all-ones; the flag fires only on reaching it.
    assign w_wdog_nxt = r_wdog + TIMEOUT_W'(1);
    assign w_wdog_inc = (r_state == S_RUN) && dma_busy && !(&r_wdog);
    assign w_expire   = w_wdog_inc && (&w_wdog_nxt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog     <= '0;
            r_err      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (r_state == S_LAUNCH)  r_wdog <= '0;
            else if (w_wdog_inc)      r_wdog <= w_wdog_nxt;

            if (w_expire)             r_err <= 1'b1;
            else if (clr_err)         r_err <= 1'b0;

            if (r_state == S_CMPL)    r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign desc_ready    = !w_full;
    assign dma_target    = r_active.target;
    assign dma_base_addr = r_active.base;
    assign dma_length    = r_active.length;
    assign dma_dir       = r_active.dir;
    assign dma_start     = (r_state == S_RUN);
    assign seq_busy      = (r_state != S_IDLE) || !w_empty;
    assign done_cnt      = r_done_cnt;
    assign irq           = (r_state == S_CMPL) && r_active.irq_en;
    assign err_timeout   = r_err;

endmodule

// File: tb/tb_dpu_dma_desc_seq.sv
// Scoreboard bench for dpu_dma_desc_seq with a behavioural DMA responder.
module tb_dpu_dma_desc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        desc_valid, desc_dir, desc_irq_en, flush, clr_err;
    logic [2:0]  desc_target;
    logic [23:0] desc_base, desc_length;
    logic        desc_ready;
    logic [2:0]  dma_target;
    logic [23:0] dma_base_addr, dma_length;
    logic        dma_dir, dma_start, dma_done, dma_busy;
    logic        seq_busy, irq, err_timeout;
    logic [3:0]  q_level;
    logic [15:0] done_cnt;

    always #5 clk = ~clk;

    dpu_dma_desc_seq #(.ADDR_BITS(24), .DEPTH(8), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_target(desc_target),
        .desc_base(desc_base), .desc_length(desc_length), .desc_dir(desc_dir),
        .desc_irq_en(desc_irq_en), .flush(flush), .clr_err(clr_err),
        .dma_target(dma_target), .dma_base_addr(dma_base_addr), .dma_length(dma_length),
        .dma_dir(dma_dir), .dma_start(dma_start), .dma_done(dma_done), .dma_busy(dma_busy),
        .seq_busy(seq_busy), .q_level(q_level), .done_cnt(done_cnt), .irq(irq),
        .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [2:0]  tgt;
        logic [23:0] base;
        logic [23:0] len;
        logic        dir;
        logic        irq;
    } exp_t;
    exp_t sb[$];

    // DMA responder: done after dma_delay start cycles unless stalled.
    int dma_delay = 3;
    bit dma_stall = 1'b0;
    int dma_cnt   = 0;
    initial begin
        dma_done = 1'b0;
        dma_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dma_done = 1'b0; dma_busy = 1'b0; dma_cnt = 0;
            end else if (dma_start && !dma_done) begin
                dma_busy = 1'b1;
                dma_cnt++;
                if (!dma_stall && dma_cnt >= dma_delay) begin
                    dma_done = 1'b1; dma_busy = 1'b0;
                end
            end else if (dma_done && !dma_start) begin
                dma_done = 1'b0; dma_cnt = 0;
            end
        end
    end

    // Completion monitor: pops the scoreboard whenever done_cnt advances.
    logic [15:0] prev_cnt   = '0;
    logic        prev_start = 1'b0;
    bit          start_seen = 1'b0;
    int          irq_cnt    = 0;
    exp_t        e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (irq) irq_cnt++;
                if (dma_start) begin
                    if (!prev_start) start_seen = 1'b1;
                    if (sb.size() > 0)
                        chk("hold_fields", {dma_target, dma_base_addr, dma_length, dma_dir},
                            {sb[0].tgt, sb[0].base, sb[0].len, sb[0].dir});
                    else
                        chk("start_unexpected", 1, 0);
                end
                if (done_cnt != prev_cnt) begin
                    chk("cnt_step", done_cnt, prev_cnt + 16'd1);
                    if (sb.size() == 0) begin
                        chk("cmpl_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        $display("cmpl #%0d tgt=%0d base=0x%0h len=%0d dir=%0d irq=%0d",
                                 done_cnt, dma_target, dma_base_addr, dma_length, dma_dir, irq_cnt);
                        chk("cmpl_fields", {dma_target, dma_base_addr, dma_length, dma_dir},
                            {e.tgt, e.base, e.len, e.dir});
                        chk("cmpl_irq_pulses", irq_cnt, e.irq);
                        chk("cmpl_start_seen", start_seen, e.len != 0);
                    end
                    irq_cnt    = 0;
                    start_seen = 1'b0;
                    prev_cnt   = done_cnt;
                end
                prev_start = dma_start;
            end
        end
    end

    task automatic push_desc(input logic [2:0] t, input logic [23:0] b, input logic [23:0] l,
                             input logic d, input logic ir, input bit do_flush);
        desc_valid = 1'b1; desc_target = t; desc_base = b; desc_length = l;
        desc_dir = d; desc_irq_en = ir; flush = do_flush;
        if (desc_ready && !do_flush) sb.push_back('{t, b, l, d, ir});
        @(negedge clk);
        desc_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget);
        int i = 0;
        while (done_cnt != target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("done_cnt", done_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0; desc_valid = 1'b0; desc_target = '0; desc_base = '0;
        desc_length = '0; desc_dir = 1'b0; desc_irq_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_ready", desc_ready, 1);
        chk("rst_level", q_level, 0);
        chk("rst_start", dma_start, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_outputs", {irq, err_timeout, seq_busy, dma_dir, dma_target, dma_base_addr, dma_length}, 0);

        // single transfer, DMA done after 20 clocks
        dma_delay = 20;
        push_desc(3'd1, 24'h10, 24'd4, 1'b0, 1'b1, 1'b0);
        wait_cnt(16'd1, 100);
        chk("t2_start_low", dma_start, 0);

        // fill: 1 in flight + 8 queued with the DMA stalled
        dma_stall = 1'b1; dma_delay = 3;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("ready_before_9th", desc_ready, 1);
            push_desc(3'(i % 5), 24'(i * 'h100 + 'h1000), 24'(i + 1), 1'(i & 1), 1'(i & 1), 1'b0);
        end
        chk("full_ready", desc_ready, 0);
        chk("full_level", q_level, 8);
        push_desc(3'd4, 24'hBEEF, 24'd9, 1'b1, 1'b1, 1'b0);
        chk("full_level_hold", q_level, 8);
        dma_stall = 1'b0;
        wait_cnt(16'd10, 300);

        // zero-length descriptors
        push_desc(3'd4, 24'h200, 24'd0, 1'b1, 1'b1, 1'b0);
        wait_cnt(16'd11, 30);
        push_desc(3'd2, 24'h300, 24'd0, 1'b0, 1'b0, 1'b0);
        wait_cnt(16'd12, 30);

        // watchdog expiry at RUN cycle 15, clear, then late done
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("err_pre_clear", err_timeout, 0);
        dma_stall = 1'b1; dma_delay = 2;
        push_desc(3'd3, 24'h400, 24'd16, 1'b1, 1'b1, 1'b0);
        begin
            int k = 0;
            while (!dma_start && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("t5_start", dma_start, 1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 14) chk("wdog_cycle14", err_timeout, 0);
        end
        chk("wdog_cycle15", err_timeout, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("err_cleared", err_timeout, 0);
        repeat (3) @(negedge clk);
        chk("err_stays_clear", err_timeout, 0);
        chk("still_running", dma_start, 1);
        dma_stall = 1'b0;
        wait_cnt(16'd13, 30);

        // flush with 3 queued during an active transfer; concurrent push dropped
        dma_stall = 1'b1; dma_delay = 2;
        for (int i = 0; i < 4; i++)
            push_desc(3'(i), 24'(i * 'h10 + 'h800), 24'(i + 2), 1'b0, 1'b1, 1'b0);
        chk("pre_flush_level", q_level, 3);
        repeat (3) sb.delete(sb.size() - 1);
        push_desc(3'd0, 24'h900, 24'd5, 1'b0, 1'b1, 1'b1);
        chk("flush_level", q_level, 0);
        chk("flush_ready", desc_ready, 1);
        chk("flush_busy", seq_busy, 1);
        dma_stall = 1'b0;
        wait_cnt(16'd14, 40);
        repeat (10) @(negedge clk);
        chk("flush_no_extra", done_cnt, 14);
        chk("end_level", q_level, 0);
        chk("end_busy", seq_busy, 0);
        chk("end_start", dma_start, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
